// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the sequence scan controller.
// Build option: define SEQ_SCAN_OVERLAP_EN for overlapping matches.
package seq_scan_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 4;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Bits needed to hold a count in the range 0..n.
  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_scan_controller_if.sv
// Word-in / result-out valid-ready handshake bundle of the scan controller.
// Build option: SEQ_SCAN_OVERLAP_EN has no effect on this bundle.
interface seq_scan_controller_if #(
  parameter int DATA_W = seq_scan_pkg::DEF_DATA_W
);
  import seq_scan_pkg::*;

  localparam int OCNT_W = count_w(DATA_W);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [OCNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count
  );

endinterface

// File: rtl/seq_window_match.sv
// Sliding-window matcher: history shifter, saturating fill count, masked compare.
// Build option: SEQ_SCAN_OVERLAP_EN keeps fill on a match; otherwise a match restarts fill.
module seq_window_match
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_match
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  w_hist_nxt;
  logic [PAT_W-1:0]  w_mask;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [LEN_W-1:0]  w_len_eff;

  // Match is judged on the window as it will look after this bit shifts in.
  always_comb begin
    w_hist_nxt = {r_hist[PAT_W-2:0], i_bit};
    w_fill_nxt = (r_fill == FILL_W'(PAT_W)) ? r_fill : (r_fill + FILL_W'(1));
    w_len_eff  = (i_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : i_len;
    w_mask     = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (LEN_W'(i) < w_len_eff);
    end
    if (i_shift && (w_len_eff != {LEN_W{1'b0}}) &&
        (LEN_W'(w_fill_nxt) >= w_len_eff) &&
        ((w_hist_nxt & w_mask) == (i_pattern & w_mask))) begin
      o_match = 1'b1;
    end else begin
      o_match = 1'b0;
    end
  end

  // History and fill registers.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_hist <= {PAT_W{1'b0}};
      r_fill <= {FILL_W{1'b0}};
    end else if (i_shift) begin
      r_hist <= w_hist_nxt;
`ifdef SEQ_SCAN_OVERLAP_EN
      r_fill <= w_fill_nxt;
`else
      r_fill <= o_match ? {FILL_W{1'b0}} : w_fill_nxt;
`endif
    end
  end

endmodule

// File: rtl/seq_scan_controller.sv
// Flow-controlled word scheduler feeding seq_window_match MSB first, per-word match count.
// Build option: SEQ_SCAN_OVERLAP_EN selects overlapping matches in the matcher.
module seq_scan_controller
  import seq_scan_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PAT_W  = DEF_PAT_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_cfg_we,
  input  logic [PAT_W-1:0]     i_cfg_pattern,
  input  logic [$clog2(PAT_W):0] i_cfg_len,
  seq_scan_controller_if.slave bus,
  output logic [CNT_W-1:0]     o_match_total,
  output logic                 o_busy
);

  localparam int LEN_W  = $clog2(PAT_W) + 1;
  localparam int OCNT_W = count_w(DATA_W);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_idx;
  logic [OCNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0]  r_total;
  logic [PAT_W-1:0]  r_pattern;
  logic [LEN_W-1:0]  r_len;
  logic              w_cfg_wr;
  logic              w_accept;
  logic              w_shift;
  logic              w_match;

  assign w_cfg_wr = (r_state == IDLE) && i_cfg_we;
  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_shift  = (r_state == SHIFT);

  seq_window_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_match (
    .i_clk     (i_clock),
    .i_rst     (i_reset),
    .i_clr     (w_cfg_wr),
    .i_shift   (w_shift),
    .i_bit     (r_data[r_idx]),
    .i_pattern (r_pattern),
    .i_len     (r_len),
    .o_match   (w_match)
  );

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = bus.in_valid ? SHIFT : IDLE;
      SHIFT:   w_state_nxt = (r_idx == {IDX_W{1'b0}}) ? REPORT : SHIFT;
      REPORT:  w_state_nxt = bus.out_ready ? IDLE : REPORT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, configuration, word datapath and counters.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_data     <= {DATA_W{1'b0}};
      r_idx      <= {IDX_W{1'b0}};
      r_word_cnt <= {OCNT_W{1'b0}};
      r_total    <= {CNT_W{1'b0}};
      r_pattern  <= {PAT_W{1'b0}};
      r_len      <= {LEN_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_cfg_wr) begin
        r_pattern <= i_cfg_pattern;
        r_len     <= i_cfg_len;
      end
      if (w_accept) begin
        r_data     <= bus.in_data;
        r_idx      <= IDX_W'(DATA_W - 1);
        r_word_cnt <= {OCNT_W{1'b0}};
      end else if (w_shift) begin
        r_idx <= r_idx - IDX_W'(1);
        if (w_match) begin
          r_word_cnt <= r_word_cnt + OCNT_W'(1);
        end
      end
      if (w_match && (r_total != {CNT_W{1'b1}})) begin
        r_total <= r_total + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == REPORT);
  assign bus.out_count = r_word_cnt;
  assign o_match_total = r_total;
  assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_seq_scan_controller.sv
// Directed, table-driven bench for seq_scan_controller (DATA_W=8, PAT_W=4).
// Expectations track the SEQ_SCAN_OVERLAP_EN build option.
module tb_seq_scan_controller;

`ifdef SEQ_SCAN_OVERLAP_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_pattern = 4'd0;
  logic [2:0] cfg_len = 3'd0;
  logic       cfg_we2 = 1'b0;
  logic [3:0] cfg_pattern2 = 4'd0;
  logic [2:0] cfg_len2 = 3'd0;
  logic [15:0] total;
  logic [1:0]  total2;
  logic        busy, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_scan_controller_if #(.DATA_W(8)) bus ();
  seq_scan_controller_if #(.DATA_W(8)) bus2 ();

  seq_scan_controller #(.DATA_W(8), .PAT_W(4), .CNT_W(16)) dut (
    .i_clock(clk), .i_reset(rst), .i_cfg_we(cfg_we), .i_cfg_pattern(cfg_pattern),
    .i_cfg_len(cfg_len), .bus(bus), .o_match_total(total), .o_busy(busy)
  );

  seq_scan_controller #(.DATA_W(8), .PAT_W(4), .CNT_W(2)) dut2 (
    .i_clock(clk), .i_reset(rst), .i_cfg_we(cfg_we2), .i_cfg_pattern(cfg_pattern2),
    .i_cfg_len(cfg_len2), .bus(bus2), .o_match_total(total2), .o_busy(busy2)
  );

  typedef struct {
    logic        do_cfg;
    logic [3:0]  pat;
    logic [2:0]  len;
    logic [7:0]  data;
    logic [3:0]  cnt_ov;
    logic [3:0]  cnt_no;
    logic [15:0] tot_ov;
    logic [15:0] tot_no;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_word(input logic do_cfg, input logic [3:0] pat, input logic [2:0] len,
                            input logic [7:0] data);
    @(negedge clk);
    cfg_we      = do_cfg;
    cfg_pattern = pat;
    cfg_len     = len;
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cfg_we       = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, " in_ready after ack"}, 32'(bus.in_ready), 32'd1);
    check({name, " out_valid after ack"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_word(input string name, input logic do_cfg, input logic [3:0] pat,
                          input logic [2:0] len, input logic [7:0] data,
                          input logic [3:0] exp_cnt, input logic [15:0] exp_tot);
    int lat;
    start_word(do_cfg, pat, len, data);
    wait_result(lat);
    check({name, " latency"}, 32'(lat), 32'd8);
    check({name, " out_count"}, 32'(bus.out_count), 32'(exp_cnt));
    check({name, " match_total"}, 32'(total), 32'(exp_tot));
    ack(name);
  endtask

  initial begin
    int lat;
    logic [3:0] exp_c;
    bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = 8'd0; bus2.out_ready = 1'b0;

    vecs[0] = '{1'b1, 4'b1011, 3'd4, 8'b1011_0110, 4'd2, 4'd1, 16'd2,  16'd1};
    vecs[1] = '{1'b1, 4'b1011, 3'd4, 8'b0000_0101, 4'd0, 4'd0, 16'd2,  16'd1};
    vecs[2] = '{1'b0, 4'b0000, 3'd0, 8'b1000_0000, 4'd1, 4'd1, 16'd3,  16'd2};
    vecs[3] = '{1'b1, 4'b1011, 3'd0, 8'hFF,        4'd0, 4'd0, 16'd3,  16'd2};
    vecs[4] = '{1'b1, 4'b1011, 3'd7, 8'b0000_1011, 4'd1, 4'd1, 16'd4,  16'd3};
    vecs[5] = '{1'b1, 4'b0101, 3'd3, 8'b1010_1010, 4'd3, 4'd2, 16'd7,  16'd5};
    vecs[6] = '{1'b1, 4'b0001, 3'd1, 8'b0110_0001, 4'd3, 4'd3, 16'd10, 16'd8};

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_count", 32'(bus.out_count), 32'd0);
    check("reset match_total", 32'(total), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_word($sformatf("vec%0d", i), vecs[i].do_cfg, vecs[i].pat, vecs[i].len, vecs[i].data,
               OV ? vecs[i].cnt_ov : vecs[i].cnt_no, OV ? vecs[i].tot_ov : vecs[i].tot_no);
    end

    // Consumer stalls the result for five cycles.
    exp_c = OV ? 4'd2 : 4'd1;
    start_word(1'b1, 4'b1011, 3'd4, 8'b1011_0110);
    wait_result(lat);
    check("hold latency", 32'(lat), 32'd8);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("hold%0d out_count", k), 32'(bus.out_count), 32'(exp_c));
      check($sformatf("hold%0d in_ready", k), 32'(bus.in_ready), 32'd0);
    end
    check("hold match_total", 32'(total), OV ? 32'd12 : 32'd9);
    ack("hold");

    // Reset lands in the third shift cycle.
    start_word(1'b1, 4'b1011, 3'd4, 8'b1011_1011);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort match_total", 32'(total), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    run_word("post_reset", 1'b1, 4'b1011, 3'd4, 8'b1011_0000, 4'd1, 16'd1);

    // Length zero disables matching.
    run_word("len0", 1'b1, 4'b1011, 3'd0, 8'hFF, 4'd0, 16'd1);

    // A write during SHIFT must be ignored.
    start_word(1'b1, 4'b1011, 3'd4, 8'hFF);
    @(posedge clk);
    #1;
    cfg_we = 1'b1; cfg_pattern = 4'b1111; cfg_len = 3'd4;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    wait_result(lat);
    check("ignored_cfg out_valid", 32'(bus.out_valid), 32'd1);
    check("ignored_cfg out_count", 32'(bus.out_count), 32'd0);
    ack("ignored_cfg");
    run_word("old_pattern", 1'b0, 4'b0000, 3'd0, 8'b0000_1011, 4'd1, 16'd2);

    // Narrow total counter saturates.
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      cfg_we2 = (w == 0); cfg_pattern2 = 4'b0011; cfg_len2 = 3'd2;
      bus2.in_data = 8'hFF; bus2.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus2.in_valid = 1'b0; cfg_we2 = 1'b0;
      lat = 0;
      while (!bus2.out_valid && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("sat%0d latency", w), 32'(lat), 32'd8);
      check($sformatf("sat%0d out_count", w), 32'(bus2.out_count),
            OV ? ((w == 0) ? 32'd7 : 32'd8) : 32'd4);
      check($sformatf("sat%0d match_total", w), 32'(total2), 32'd3);
      bus2.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus2.out_ready = 1'b0;
      check($sformatf("sat%0d in_ready", w), 32'(bus2.in_ready), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
